// File: rtl/mulf_iter.sv
// rtl/mulf_iter.sv - iterative parametrised floating-point multiplier with valid/ready handshakes
//
// Purpose:
//    Multiplies two IEEE-style floating-point operands of configurable width.
//    The significand product is formed by a shift-add loop that consumes one
//    multiplier bit per cycle, followed by one normalise cycle and one
//    round-to-nearest-even cycle. NaN/Inf/zero operands bypass the loop.
//    Subnormal operands are flushed to zero. Results that overflow become
//    signed infinity, and results that underflow become signed zero.
//
// Ports:
//    clk        in   1   rising-edge clock
//    rst        in   1   synchronous active-high reset
//    in_valid   in   1   operands a/b valid
//    in_ready   out  1   accepting operands (IDLE and not in reset)
//    a, b       in   W   operands {sign, exp, frac}, W = 1+EXP_W+MAN_W
//    out_valid  out  1   s and flags valid
//    out_ready  in   1   consumer takes the result
//    s          out  W   product
//    flag_nan   out  1   NaN result (NaN operand or inf x zero)
//    flag_ovf   out  1   overflow, s forced to signed infinity
//    flag_unf   out  1   underflow, s flushed to signed zero

module mulf_iter #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [EXP_W+MAN_W:0]   a,
   input  logic [EXP_W+MAN_W:0]   b,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [EXP_W+MAN_W:0]   s,
   output logic                   flag_nan,
   output logic                   flag_ovf,
   output logic                   flag_unf
);

   // Significand width including the hidden bit.
   localparam int N  = MAN_W + 1;
   // Exponent register width: two extra bits give headroom for ea+eb and a sign.
   localparam int EW = EXP_W + 2;
   localparam int CW = $clog2(N + 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_MUL   = 3'd1;
   localparam logic [2:0] S_NORM  = 3'd2;
   localparam logic [2:0] S_ROUND = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   localparam logic [EXP_W+MAN_W:0]   QNAN     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
   localparam logic [EXP_W+MAN_W-1:0] INF_MAG  = {{EXP_W{1'b1}}, {MAN_W{1'b0}}};
   localparam logic [EXP_W+MAN_W-1:0] ZERO_MAG = '0;
   localparam logic [EW-1:0]          BIAS_E   = {3'b000, {(EXP_W-1){1'b1}}};
   localparam logic [EW-1:0]          MAX_E    = {2'b00, {EXP_W{1'b1}}};
   localparam logic [EW-1:0]          ONE_E    = {{(EW-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0]          CNT_LAST = CW'(MAN_W);
   localparam logic [CW-1:0]          CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

   // ------------------------------------------------------------------
   // State and datapath registers
   // ------------------------------------------------------------------
   logic [2:0]           state_q,  state_d;
   logic                 sign_q,   sign_d;
   logic [EW-1:0]        exp_q,    exp_d;
   logic [2*N-1:0]       prod_q,   prod_d;
   logic [N-1:0]         mcand_q,  mcand_d;
   logic [CW-1:0]        cnt_q,    cnt_d;
   logic [MAN_W-1:0]     frac_q,   frac_d;
   logic                 guard_q,  guard_d;
   logic                 sticky_q, sticky_d;
   logic [EXP_W+MAN_W:0] s_q,      s_d;
   logic                 nan_q,    nan_d;
   logic                 ovf_q,    ovf_d;
   logic                 unf_q,    unf_d;

   // ------------------------------------------------------------------
   // Operand classification
   // ------------------------------------------------------------------
   logic [EXP_W-1:0] ea, eb;
   logic [MAN_W-1:0] fa, fb;
   logic             a_nan, a_inf, a_zero;
   logic             b_nan, b_inf, b_zero;
   logic             sign_in;
   logic             special_in;

   always_comb begin
      ea      = a[EXP_W+MAN_W-1:MAN_W];
      eb      = b[EXP_W+MAN_W-1:MAN_W];
      fa      = a[MAN_W-1:0];
      fb      = b[MAN_W-1:0];
      a_nan   = (&ea) & (|fa);
      a_inf   = (&ea) & ~(|fa);
      // exponent zero covers both true zero and subnormals (flush-to-zero)
      a_zero  = ~(|ea);
      b_nan   = (&eb) & (|fb);
      b_inf   = (&eb) & ~(|fb);
      b_zero  = ~(|eb);
      sign_in = a[EXP_W+MAN_W] ^ b[EXP_W+MAN_W];
      special_in = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;
   end

   // ------------------------------------------------------------------
   // Shift-add step: the multiplier starts in the low half of prod_q and
   // is shifted out as partial sums shift in from the top, so only an
   // N+1-bit adder is needed.
   // ------------------------------------------------------------------
   logic [N:0]     mul_add;
   logic [2*N-1:0] prod_step;

   always_comb begin
      mul_add   = {1'b0, prod_q[2*N-1:N]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
      prod_step = {mul_add, prod_q[N-1:1]};
   end

   // ------------------------------------------------------------------
   // Normalisation: product lies in [1,4), binary point below bit 2N-2.
   // ------------------------------------------------------------------
   logic [MAN_W-1:0] norm_frac;
   logic             norm_guard;
   logic             norm_sticky;
   logic             norm_hi;

   always_comb begin
      norm_hi = prod_q[2*N-1];
      if (norm_hi) begin
         norm_frac   = prod_q[2*N-2:N];
         norm_guard  = prod_q[N-1];
         norm_sticky = |prod_q[N-2:0];
      end else begin
         norm_frac   = prod_q[2*N-3:N-1];
         norm_guard  = prod_q[N-2];
         norm_sticky = |prod_q[N-3:0];
      end
   end

   // ------------------------------------------------------------------
   // Rounding (nearest-even) and range check
   // ------------------------------------------------------------------
   logic             round_up;
   logic [MAN_W:0]   frac_sum;
   logic [EW-1:0]    exp_r;
   logic             is_ovf;
   logic             is_unf;

   always_comb begin
      round_up = guard_q & (sticky_q | frac_q[0]);
      frac_sum = {1'b0, frac_q} + {{MAN_W{1'b0}}, round_up};
      // a carry out of the fraction leaves it all-zero, which is exactly
      // the renormalised 1.0 significand with the exponent bumped
      exp_r    = frac_sum[MAN_W] ? (exp_q + ONE_E) : exp_q;
      is_ovf   = ~exp_r[EW-1] & (exp_r >= MAX_E);
      is_unf   = exp_r[EW-1] | (exp_r == '0);
   end

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      sign_d   = sign_q;
      exp_d    = exp_q;
      prod_d   = prod_q;
      mcand_d  = mcand_q;
      cnt_d    = cnt_q;
      frac_d   = frac_q;
      guard_d  = guard_q;
      sticky_d = sticky_q;
      s_d      = s_q;
      nan_d    = nan_q;
      ovf_d    = ovf_q;
      unf_d    = unf_q;

      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               nan_d   = 1'b0;
               ovf_d   = 1'b0;
               unf_d   = 1'b0;
               sign_d  = sign_in;
               exp_d   = {2'b00, ea} + {2'b00, eb} - BIAS_E;
               mcand_d = {1'b1, fa};
               prod_d  = {{N{1'b0}}, 1'b1, fb};
               cnt_d   = '0;
               if (special_in) begin
                  state_d = S_DONE;
                  if (a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero)) begin
                     s_d   = QNAN;
                     nan_d = 1'b1;
                  end else if (a_inf | b_inf) begin
                     s_d = {sign_in, INF_MAG};
                  end else begin
                     s_d = {sign_in, ZERO_MAG};
                  end
               end else begin
                  state_d = S_MUL;
               end
            end
         end

         S_MUL: begin
            prod_d = prod_step;
            cnt_d  = cnt_q + CNT_ONE;
            if (cnt_q == CNT_LAST) begin
               state_d = S_NORM;
            end
         end

         S_NORM: begin
            frac_d   = norm_frac;
            guard_d  = norm_guard;
            sticky_d = norm_sticky;
            if (norm_hi) begin
               exp_d = exp_q + ONE_E;
            end
            state_d = S_ROUND;
         end

         S_ROUND: begin
            state_d = S_DONE;
            if (is_ovf) begin
               s_d   = {sign_q, INF_MAG};
               ovf_d = 1'b1;
            end else if (is_unf) begin
               s_d   = {sign_q, ZERO_MAG};
               unf_d = 1'b1;
            end else begin
               s_d = {sign_q, exp_r[EXP_W-1:0], frac_sum[MAN_W-1:0]};
            end
         end

         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         sign_q   <= 1'b0;
         exp_q    <= '0;
         prod_q   <= '0;
         mcand_q  <= '0;
         cnt_q    <= '0;
         frac_q   <= '0;
         guard_q  <= 1'b0;
         sticky_q <= 1'b0;
         s_q      <= '0;
         nan_q    <= 1'b0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         sign_q   <= sign_d;
         exp_q    <= exp_d;
         prod_q   <= prod_d;
         mcand_q  <= mcand_d;
         cnt_q    <= cnt_d;
         frac_q   <= frac_d;
         guard_q  <= guard_d;
         sticky_q <= sticky_d;
         s_q      <= s_d;
         nan_q    <= nan_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE) && !rst;
   assign out_valid = (state_q == S_DONE);
   assign s         = s_q;
   assign flag_nan  = nan_q;
   assign flag_ovf  = ovf_q;
   assign flag_unf  = unf_q;

endmodule

// File: tb/tb_mulf_iter.sv
// tb/tb_mulf_iter.sv - directed self-checking bench for mulf_iter (single and half precision)

module tb_mulf_iter;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   // single precision instance
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] s;
   logic        flag_nan;
   logic        flag_ovf;
   logic        flag_unf;

   // half precision instance
   logic        h_rst;
   logic        h_in_valid;
   logic        h_in_ready;
   logic [15:0] h_a;
   logic [15:0] h_b;
   logic        h_out_valid;
   logic        h_out_ready;
   logic [15:0] h_s;
   logic        h_flag_nan;
   logic        h_flag_ovf;
   logic        h_flag_unf;

   int n_checks = 0;
   int n_fail   = 0;

   mulf_iter #(.EXP_W(8), .MAN_W(23)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .s         (s),
      .flag_nan  (flag_nan),
      .flag_ovf  (flag_ovf),
      .flag_unf  (flag_unf)
   );

   mulf_iter #(.EXP_W(5), .MAN_W(10)) dut_h (
      .clk       (clk),
      .rst       (h_rst),
      .in_valid  (h_in_valid),
      .in_ready  (h_in_ready),
      .a         (h_a),
      .b         (h_b),
      .out_valid (h_out_valid),
      .out_ready (h_out_ready),
      .s         (h_s),
      .flag_nan  (h_flag_nan),
      .flag_ovf  (h_flag_ovf),
      .flag_unf  (h_flag_unf)
   );

   // {a, b, expected s, expected {nan, ovf, unf}, expected latency}
   typedef struct {
      logic [31:0] va;
      logic [31:0] vb;
      logic [31:0] vs;
      logic [2:0]  vf;
      int          vlat;
   } vec_t;

   // normal-path latency counts edges after the accept edge (MAN_W+3);
   // special-path results are already valid right after the accept edge
   vec_t normal_vecs[4] = '{
      '{32'h3F800000, 32'h40A00000, 32'h40A00000, 3'b000, 26},
      '{32'hC0A00000, 32'h40400000, 32'hC1700000, 3'b000, 26},
      '{32'hC0400000, 32'hC0666666, 32'h412CCCCC, 3'b000, 26},
      '{32'h3FC00000, 32'h3F800001, 32'h3FC00002, 3'b000, 26}
   };

   vec_t special_vecs[5] = '{
      '{32'h7F800000, 32'h00000000, 32'h7FC00000, 3'b100, 0},
      '{32'hFF800000, 32'h40000000, 32'hFF800000, 3'b000, 0},
      '{32'h80000000, 32'h3F800000, 32'h80000000, 3'b000, 0},
      '{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 3'b100, 0},
      '{32'h00000001, 32'h40000000, 32'h00000000, 3'b000, 0}
   };

   vec_t range_vecs[2] = '{
      '{32'h7F000000, 32'h7F000000, 32'h7F800000, 3'b010, 26},
      '{32'h00800000, 32'h00800000, 32'h00000000, 3'b001, 26}
   };

   task automatic issue(input logic [31:0] ia, input logic [31:0] ib);
      int k;
      k = 0;
      while (!in_ready && k < 100) begin
         @(posedge clk); #1;
         k++;
      end
      in_valid = 1'b1;
      a        = ia;
      b        = ib;
      @(posedge clk); #1;
      in_valid = 1'b0;
      a        = 32'hDEADBEEF;
      b        = 32'h12345678;
   endtask

   task automatic wait_out(input int budget, output int lat);
      lat = 0;
      while (!out_valid && lat < budget) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      h_rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if (in_ready !== 1'b0) begin
         n_fail++; $display("FAIL reset_in_ready: got %b expected 0", in_ready);
      end
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid);
      end
      n_checks++;
      if (s !== 32'h0) begin
         n_fail++; $display("FAIL reset_s: got %h expected 00000000", s);
      end
      n_checks++;
      if ({flag_nan, flag_ovf, flag_unf} !== 3'b000) begin
         n_fail++; $display("FAIL reset_flags: got %b expected 000", {flag_nan, flag_ovf, flag_unf});
      end
      rst = 1'b0;
      h_rst = 1'b0;
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fail++; $display("FAIL reset_release_in_ready: got %b expected 1", in_ready);
      end
   endtask

   task automatic test_normal;
      int lat;
      foreach (normal_vecs[i]) begin
         issue(normal_vecs[i].va, normal_vecs[i].vb);
         wait_out(60, lat);
         n_checks++;
         if (lat !== normal_vecs[i].vlat) begin
            n_fail++; $display("FAIL normal_latency[%0d]: got %0d expected %0d", i, lat, normal_vecs[i].vlat);
         end
         n_checks++;
         if (s !== normal_vecs[i].vs) begin
            n_fail++; $display("FAIL normal_s[%0d]: got %h expected %h", i, s, normal_vecs[i].vs);
         end
         n_checks++;
         if ({flag_nan, flag_ovf, flag_unf} !== normal_vecs[i].vf) begin
            n_fail++; $display("FAIL normal_flags[%0d]: got %b expected %b", i, {flag_nan, flag_ovf, flag_unf}, normal_vecs[i].vf);
         end
         @(posedge clk); #1;
         n_checks++;
         if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++; $display("FAIL normal_after_handshake[%0d]: got out_valid,in_ready=%b expected 01", i, {out_valid, in_ready});
         end
      end
   endtask

   task automatic test_special;
      int lat;
      foreach (special_vecs[i]) begin
         issue(special_vecs[i].va, special_vecs[i].vb);
         wait_out(60, lat);
         n_checks++;
         if (lat !== special_vecs[i].vlat) begin
            n_fail++; $display("FAIL special_latency[%0d]: got %0d expected %0d", i, lat, special_vecs[i].vlat);
         end
         n_checks++;
         if (s !== special_vecs[i].vs) begin
            n_fail++; $display("FAIL special_s[%0d]: got %h expected %h", i, s, special_vecs[i].vs);
         end
         n_checks++;
         if ({flag_nan, flag_ovf, flag_unf} !== special_vecs[i].vf) begin
            n_fail++; $display("FAIL special_flags[%0d]: got %b expected %b", i, {flag_nan, flag_ovf, flag_unf}, special_vecs[i].vf);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_range;
      int lat;
      foreach (range_vecs[i]) begin
         issue(range_vecs[i].va, range_vecs[i].vb);
         wait_out(60, lat);
         n_checks++;
         if (lat !== range_vecs[i].vlat) begin
            n_fail++; $display("FAIL range_latency[%0d]: got %0d expected %0d", i, lat, range_vecs[i].vlat);
         end
         n_checks++;
         if (s !== range_vecs[i].vs) begin
            n_fail++; $display("FAIL range_s[%0d]: got %h expected %h", i, s, range_vecs[i].vs);
         end
         n_checks++;
         if ({flag_nan, flag_ovf, flag_unf} !== range_vecs[i].vf) begin
            n_fail++; $display("FAIL range_flags[%0d]: got %b expected %b", i, {flag_nan, flag_ovf, flag_unf}, range_vecs[i].vf);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_backpressure;
      int lat;
      out_ready = 1'b0;
      issue(32'h3F800000, 32'h40A00000);
      wait_out(60, lat);
      n_checks++;
      if (lat !== 26) begin
         n_fail++; $display("FAIL bp_latency: got %0d expected 26", lat);
      end
      // a new request while DONE must be ignored
      in_valid = 1'b1;
      a        = 32'h40400000;
      b        = 32'h40400000;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         n_checks++;
         if ({out_valid, in_ready} !== 2'b10) begin
            n_fail++; $display("FAIL bp_hold_handshake[%0d]: got out_valid,in_ready=%b expected 10", c, {out_valid, in_ready});
         end
         n_checks++;
         if (s !== 32'h40A00000) begin
            n_fail++; $display("FAIL bp_hold_s[%0d]: got %h expected 40a00000", c, s);
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if ({out_valid, in_ready} !== 2'b01) begin
         n_fail++; $display("FAIL bp_release: got out_valid,in_ready=%b expected 01", {out_valid, in_ready});
      end
      @(posedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++; $display("FAIL bp_single_handshake: got out_valid=%b expected 0", out_valid);
      end
   endtask

   task automatic test_reset_mid;
      int lat;
      int seen;
      issue(32'h40400000, 32'h40400000);
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if ({out_valid, in_ready} !== 2'b00) begin
         n_fail++; $display("FAIL midrst_during: got out_valid,in_ready=%b expected 00", {out_valid, in_ready});
      end
      rst = 1'b0;
      #1;
      n_checks++;
      if ({out_valid, in_ready} !== 2'b01) begin
         n_fail++; $display("FAIL midrst_after: got out_valid,in_ready=%b expected 01", {out_valid, in_ready});
      end
      seen = 0;
      for (int c = 0; c < 30; c++) begin
         @(posedge clk); #1;
         if (out_valid) seen++;
      end
      n_checks++;
      if (seen !== 0) begin
         n_fail++; $display("FAIL midrst_no_output: got %0d valid cycles expected 0", seen);
      end
      issue(32'h40400000, 32'h40400000);
      wait_out(60, lat);
      n_checks++;
      if (lat !== 26) begin
         n_fail++; $display("FAIL midrst_next_latency: got %0d expected 26", lat);
      end
      n_checks++;
      if (s !== 32'h41100000) begin
         n_fail++; $display("FAIL midrst_next_s: got %h expected 41100000", s);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_half;
      logic [15:0] ha[2] = '{16'h3E00, 16'h3C00};
      logic [15:0] hb[2] = '{16'h4000, 16'hC500};
      logic [15:0] hs[2] = '{16'h4200, 16'hC500};
      int lat;
      int k;
      for (int i = 0; i < 2; i++) begin
         k = 0;
         while (!h_in_ready && k < 100) begin
            @(posedge clk); #1;
            k++;
         end
         h_in_valid = 1'b1;
         h_a        = ha[i];
         h_b        = hb[i];
         @(posedge clk); #1;
         h_in_valid = 1'b0;
         h_a        = 16'hFFFF;
         h_b        = 16'hFFFF;
         lat = 0;
         while (!h_out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
         end
         n_checks++;
         if (lat !== 13) begin
            n_fail++; $display("FAIL half_latency[%0d]: got %0d expected 13", i, lat);
         end
         n_checks++;
         if (h_s !== hs[i]) begin
            n_fail++; $display("FAIL half_s[%0d]: got %h expected %h", i, h_s, hs[i]);
         end
         n_checks++;
         if ({h_flag_nan, h_flag_ovf, h_flag_unf} !== 3'b000) begin
            n_fail++; $display("FAIL half_flags[%0d]: got %b expected 000", i, {h_flag_nan, h_flag_ovf, h_flag_unf});
         end
         @(posedge clk); #1;
      end
   endtask

   initial begin
      rst         = 1'b1;
      in_valid    = 1'b0;
      out_ready   = 1'b1;
      a           = '0;
      b           = '0;
      h_rst       = 1'b1;
      h_in_valid  = 1'b0;
      h_out_ready = 1'b1;
      h_a         = '0;
      h_b         = '0;

      test_reset;
      test_normal;
      test_special;
      test_range;
      test_backpressure;
      test_reset_mid;
      test_half;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
